// File: rtl/alu_reservation_station.sv
// Holds decoded integer/branch ops until both operands resolve and issues the lowest ready entry on registered outputs.
// Latency: ready-at-dispatch ops reach the ALU outputs two edges after dispatch; the producer must honour rs_dec_full_out, and rdy_in low stalls everything.
module alu_reservation_station #(
  parameter int RS_SIZE_LOG     = 3,
  parameter int ID_WIDTH        = 32,
  parameter int ROB_WIDTH       = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int INST_TYPE_WIDTH = 6,
  parameter logic [INST_TYPE_WIDTH-1:0] NOP = '0
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       dec_rs_en_in,
  input  logic [INST_TYPE_WIDTH-1:0] dec_rs_opcode_in,
  input  logic [ID_WIDTH-1:0]        dec_rs_vj_in,
  input  logic [ID_WIDTH-1:0]        dec_rs_vk_in,
  input  logic [ROB_WIDTH-1:0]       dec_rs_qj_in,
  input  logic [ROB_WIDTH-1:0]       dec_rs_qk_in,
  input  logic [ID_WIDTH-1:0]        dec_rs_a_in,
  input  logic [ADDR_WIDTH-1:0]      dec_rs_pc_in,
  input  logic [ROB_WIDTH-1:0]       dec_rs_dest_in,
  output logic                       rs_dec_full_out,
  input  logic [ROB_WIDTH-1:0]       alu_rs_h_in,
  input  logic [ID_WIDTH-1:0]        alu_rs_result_in,
  input  logic [ROB_WIDTH-1:0]       lsb_rs_h_in,
  input  logic [ID_WIDTH-1:0]        lsb_rs_result_in,
  input  logic                       rob_rs_rst_in,
  output logic [ID_WIDTH-1:0]        rs_alu_a_out,
  output logic [ID_WIDTH-1:0]        rs_alu_vj_out,
  output logic [ID_WIDTH-1:0]        rs_alu_vk_out,
  output logic [ROB_WIDTH-1:0]       rs_alu_dest_out,
  output logic [ADDR_WIDTH-1:0]      rs_alu_pc_out,
  output logic [INST_TYPE_WIDTH-1:0] rs_alu_opcode_out
);

  localparam int RS_SIZE = 1 << RS_SIZE_LOG;

  typedef struct packed {
    logic                       busy;
    logic [INST_TYPE_WIDTH-1:0] opcode;
    logic [ID_WIDTH-1:0]        vj;
    logic [ROB_WIDTH-1:0]       qj;
    logic [ID_WIDTH-1:0]        vk;
    logic [ROB_WIDTH-1:0]       qk;
    logic [ID_WIDTH-1:0]        a;
    logic [ADDR_WIDTH-1:0]      pc;
    logic [ROB_WIDTH-1:0]       dest;
  } entry_t;

  entry_t ent_q [RS_SIZE];
  entry_t ent_d [RS_SIZE];
  entry_t new_ent;
  entry_t iss_ent;

  logic [RS_SIZE-1:0]     busy_vec;
  logic [RS_SIZE-1:0]     ready_vec;
  logic [RS_SIZE_LOG-1:0] free_idx;
  logic [RS_SIZE_LOG-1:0] issue_idx;
  logic                   issue_vld;
  logic                   disp_vld;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_vec[i]  = ent_q[i].busy;
      ready_vec[i] = ent_q[i].busy && (ent_q[i].qj == '0) && (ent_q[i].qk == '0);
    end
  end

  assign rs_dec_full_out = &busy_vec;
  assign issue_vld       = |ready_vec;
  assign disp_vld        = dec_rs_en_in && !rs_dec_full_out;
  assign iss_ent         = ent_q[issue_idx];

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    free_idx  = '0;
    issue_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_vec[i])  free_idx  = RS_SIZE_LOG'(i);
      if (ready_vec[i])  issue_idx = RS_SIZE_LOG'(i);
    end
  end

  // Incoming operands can be satisfied by a broadcast in the very cycle they arrive.
  always_comb begin
    new_ent        = '0;
    new_ent.busy   = 1'b1;
    new_ent.opcode = dec_rs_opcode_in;
    new_ent.vj     = dec_rs_vj_in;
    new_ent.qj     = dec_rs_qj_in;
    new_ent.vk     = dec_rs_vk_in;
    new_ent.qk     = dec_rs_qk_in;
    new_ent.a      = dec_rs_a_in;
    new_ent.pc     = dec_rs_pc_in;
    new_ent.dest   = dec_rs_dest_in;
    if (dec_rs_qj_in != '0) begin
      if (dec_rs_qj_in == alu_rs_h_in) begin
        new_ent.vj = alu_rs_result_in;
        new_ent.qj = '0;
      end else if (dec_rs_qj_in == lsb_rs_h_in) begin
        new_ent.vj = lsb_rs_result_in;
        new_ent.qj = '0;
      end
    end
    if (dec_rs_qk_in != '0) begin
      if (dec_rs_qk_in == alu_rs_h_in) begin
        new_ent.vk = alu_rs_result_in;
        new_ent.qk = '0;
      end else if (dec_rs_qk_in == lsb_rs_h_in) begin
        new_ent.vk = lsb_rs_result_in;
        new_ent.qk = '0;
      end
    end
  end

  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ent_q[i].busy) begin
        if (alu_rs_h_in != '0 && ent_q[i].qj == alu_rs_h_in) begin
          ent_d[i].vj = alu_rs_result_in;
          ent_d[i].qj = '0;
        end
        if (lsb_rs_h_in != '0 && ent_q[i].qj == lsb_rs_h_in) begin
          ent_d[i].vj = lsb_rs_result_in;
          ent_d[i].qj = '0;
        end
        if (alu_rs_h_in != '0 && ent_q[i].qk == alu_rs_h_in) begin
          ent_d[i].vk = alu_rs_result_in;
          ent_d[i].qk = '0;
        end
        if (lsb_rs_h_in != '0 && ent_q[i].qk == lsb_rs_h_in) begin
          ent_d[i].vk = lsb_rs_result_in;
          ent_d[i].qk = '0;
        end
      end
    end
    if (issue_vld) ent_d[issue_idx].busy = 1'b0;
    if (disp_vld)  ent_d[free_idx] = new_ent;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || rob_rs_rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      rs_alu_a_out      <= '0;
      rs_alu_vj_out     <= '0;
      rs_alu_vk_out     <= '0;
      rs_alu_dest_out   <= '0;
      rs_alu_pc_out     <= '0;
      rs_alu_opcode_out <= NOP;
    end else if (rdy_in) begin
      ent_q <= ent_d;
      if (issue_vld) begin
        rs_alu_a_out      <= iss_ent.a;
        rs_alu_vj_out     <= iss_ent.vj;
        rs_alu_vk_out     <= iss_ent.vk;
        rs_alu_dest_out   <= iss_ent.dest;
        rs_alu_pc_out     <= iss_ent.pc;
        rs_alu_opcode_out <= iss_ent.opcode;
      end else begin
        rs_alu_dest_out   <= '0;
        rs_alu_opcode_out <= NOP;
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed scenarios plus a randomized run checked against an array-based model of the station.
module tb_alu_reservation_station;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_ADDI = 6'd2;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, dec_rs_en_in, rob_rs_rst_in, rs_dec_full_out;
  logic [5:0]  dec_rs_opcode_in, rs_alu_opcode_out;
  logic [31:0] dec_rs_vj_in, dec_rs_vk_in, dec_rs_a_in, dec_rs_pc_in;
  logic [3:0]  dec_rs_qj_in, dec_rs_qk_in, dec_rs_dest_in, alu_rs_h_in, lsb_rs_h_in, rs_alu_dest_out;
  logic [31:0] alu_rs_result_in, lsb_rs_result_in;
  logic [31:0] rs_alu_a_out, rs_alu_vj_out, rs_alu_vk_out, rs_alu_pc_out;

  int checks = 0;
  int errors = 0;

  alu_reservation_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .dec_rs_en_in(dec_rs_en_in), .dec_rs_opcode_in(dec_rs_opcode_in),
    .dec_rs_vj_in(dec_rs_vj_in), .dec_rs_vk_in(dec_rs_vk_in),
    .dec_rs_qj_in(dec_rs_qj_in), .dec_rs_qk_in(dec_rs_qk_in),
    .dec_rs_a_in(dec_rs_a_in), .dec_rs_pc_in(dec_rs_pc_in),
    .dec_rs_dest_in(dec_rs_dest_in), .rs_dec_full_out(rs_dec_full_out),
    .alu_rs_h_in(alu_rs_h_in), .alu_rs_result_in(alu_rs_result_in),
    .lsb_rs_h_in(lsb_rs_h_in), .lsb_rs_result_in(lsb_rs_result_in),
    .rob_rs_rst_in(rob_rs_rst_in),
    .rs_alu_a_out(rs_alu_a_out), .rs_alu_vj_out(rs_alu_vj_out), .rs_alu_vk_out(rs_alu_vk_out),
    .rs_alu_dest_out(rs_alu_dest_out), .rs_alu_pc_out(rs_alu_pc_out),
    .rs_alu_opcode_out(rs_alu_opcode_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: eight slots held as plain arrays, plus the expected ALU-side outputs.
  logic        m_busy [8];
  logic [5:0]  m_op   [8];
  logic [31:0] m_vj [8], m_vk [8], m_a [8], m_pc [8];
  logic [3:0]  m_qj [8], m_qk [8], m_dest [8];
  logic [5:0]  e_op;
  logic [3:0]  e_dest;
  logic [31:0] e_a, e_vj, e_vk, e_pc;

  function automatic bit m_full();
    int n = 0;
    for (int i = 0; i < 8; i++) if (m_busy[i]) n++;
    return n == 8;
  endfunction

  function automatic logic [31:0] resolve(input logic [3:0] q, input logic [31:0] v);
    if (q != 0 && q == alu_rs_h_in) return alu_rs_result_in;
    if (q != 0 && q == lsb_rs_h_in) return lsb_rs_result_in;
    return v;
  endfunction

  function automatic logic [3:0] resolve_tag(input logic [3:0] q);
    if (q != 0 && (q == alu_rs_h_in || q == lsb_rs_h_in)) return 4'd0;
    return q;
  endfunction

  task automatic model_update();
    int iss = -1;
    int fr = -1;
    bit full = m_full();
    if (rst_in || rob_rs_rst_in) begin
      for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
      e_op = OP_NOP; e_dest = 0; e_a = 0; e_vj = 0; e_vk = 0; e_pc = 0;
    end else if (rdy_in) begin
      for (int i = 0; i < 8; i++) begin
        if (iss < 0 && m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0) iss = i;
        if (fr < 0 && !m_busy[i]) fr = i;
      end
      if (iss >= 0) begin
        e_op = m_op[iss]; e_dest = m_dest[iss]; e_a = m_a[iss];
        e_vj = m_vj[iss]; e_vk = m_vk[iss]; e_pc = m_pc[iss];
        m_busy[iss] = 1'b0;
      end else begin
        e_op = OP_NOP; e_dest = 0;
      end
      for (int i = 0; i < 8; i++) begin
        if (m_busy[i]) begin
          m_vj[i] = resolve(m_qj[i], m_vj[i]); m_qj[i] = resolve_tag(m_qj[i]);
          m_vk[i] = resolve(m_qk[i], m_vk[i]); m_qk[i] = resolve_tag(m_qk[i]);
        end
      end
      if (dec_rs_en_in && !full) begin
        m_busy[fr] = 1'b1; m_op[fr] = dec_rs_opcode_in; m_a[fr] = dec_rs_a_in;
        m_pc[fr] = dec_rs_pc_in; m_dest[fr] = dec_rs_dest_in;
        m_vj[fr] = resolve(dec_rs_qj_in, dec_rs_vj_in); m_qj[fr] = resolve_tag(dec_rs_qj_in);
        m_vk[fr] = resolve(dec_rs_qk_in, dec_rs_vk_in); m_qk[fr] = resolve_tag(dec_rs_qk_in);
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    rst_in = 0; rdy_in = 1; rob_rs_rst_in = 0; dec_rs_en_in = 0;
    dec_rs_opcode_in = OP_NOP; dec_rs_vj_in = 0; dec_rs_vk_in = 0; dec_rs_qj_in = 0;
    dec_rs_qk_in = 0; dec_rs_a_in = 0; dec_rs_pc_in = 0; dec_rs_dest_in = 0;
    alu_rs_h_in = 0; alu_rs_result_in = 0; lsb_rs_h_in = 0; lsb_rs_result_in = 0;
  endtask

  task automatic dispatch(input logic [5:0] op, input logic [3:0] dest, input logic [31:0] vj,
                          input logic [3:0] qj, input logic [31:0] vk, input logic [3:0] qk,
                          input logic [31:0] a, input logic [31:0] pc);
    dec_rs_en_in = 1; dec_rs_opcode_in = op; dec_rs_dest_in = dest;
    dec_rs_vj_in = vj; dec_rs_qj_in = qj; dec_rs_vk_in = vk; dec_rs_qk_in = qk;
    dec_rs_a_in = a; dec_rs_pc_in = pc;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1;
    step(); step();
    rst_in = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (rs_alu_opcode_out !== OP_NOP) begin errors++; $display("FAIL reset_op got %0d want %0d", rs_alu_opcode_out, OP_NOP); end
    if (rs_alu_dest_out !== 4'd0) begin errors++; $display("FAIL reset_dest got %0d want 0", rs_alu_dest_out); end
    if (rs_alu_vj_out !== 32'd0 || rs_alu_vk_out !== 32'd0) begin errors++; $display("FAIL reset_v got %h/%h want 0", rs_alu_vj_out, rs_alu_vk_out); end
    if (rs_alu_a_out !== 32'd0) begin errors++; $display("FAIL reset_a got %h want 0", rs_alu_a_out); end
    if (rs_alu_pc_out !== 32'd0) begin errors++; $display("FAIL reset_pc got %h want 0", rs_alu_pc_out); end
    if (rs_dec_full_out !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", rs_dec_full_out); end
  endtask

  task automatic test_addi();
    dispatch(OP_ADDI, 4'd3, 32'd5, 4'd0, 32'd0, 4'd0, 32'd7, 32'h1000);
    step();
    idle_inputs();
    checks++;
    if (rs_alu_opcode_out !== OP_NOP) begin errors++; $display("FAIL addi_early got op %0d want %0d", rs_alu_opcode_out, OP_NOP); end
    step();
    checks += 5;
    if (rs_alu_opcode_out !== OP_ADDI) begin errors++; $display("FAIL addi_op got %0d want %0d", rs_alu_opcode_out, OP_ADDI); end
    if (rs_alu_dest_out !== 4'd3) begin errors++; $display("FAIL addi_dest got %0d want 3", rs_alu_dest_out); end
    if (rs_alu_vj_out !== 32'd5) begin errors++; $display("FAIL addi_vj got %0d want 5", rs_alu_vj_out); end
    if (rs_alu_a_out !== 32'd7) begin errors++; $display("FAIL addi_a got %0d want 7", rs_alu_a_out); end
    if (rs_alu_pc_out !== 32'h1000) begin errors++; $display("FAIL addi_pc got %h want 1000", rs_alu_pc_out); end
    step();
    checks += 2;
    if (rs_alu_opcode_out !== OP_NOP || rs_alu_dest_out !== 4'd0) begin errors++; $display("FAIL addi_idle got op %0d dest %0d want NOP/0", rs_alu_opcode_out, rs_alu_dest_out); end
    if (rs_alu_vj_out !== 32'd5) begin errors++; $display("FAIL addi_hold got vj %0d want 5", rs_alu_vj_out); end
  endtask

  task automatic test_wakeup();
    dispatch(OP_ADD, 4'd4, 32'd0, 4'd2, 32'd1, 4'd0, 32'd0, 32'h2000);
    step();
    idle_inputs();
    step();
    checks++;
    if (rs_alu_opcode_out !== OP_NOP) begin errors++; $display("FAIL wake_wait got op %0d want NOP", rs_alu_opcode_out); end
    alu_rs_h_in = 4'd2; alu_rs_result_in = 32'd9;
    step();
    idle_inputs();
    checks++;
    if (rs_alu_opcode_out !== OP_NOP) begin errors++; $display("FAIL wake_edge got op %0d want NOP", rs_alu_opcode_out); end
    step();
    checks += 3;
    if (rs_alu_dest_out !== 4'd4) begin errors++; $display("FAIL wake_dest got %0d want 4", rs_alu_dest_out); end
    if (rs_alu_vj_out !== 32'd9) begin errors++; $display("FAIL wake_vj got %0d want 9", rs_alu_vj_out); end
    if (rs_alu_vk_out !== 32'd1) begin errors++; $display("FAIL wake_vk got %0d want 1", rs_alu_vk_out); end
  endtask

  task automatic test_forward();
    dispatch(OP_ADD, 4'd5, 32'd0, 4'd6, 32'd2, 4'd0, 32'd0, 32'h3000);
    lsb_rs_h_in = 4'd6; lsb_rs_result_in = 32'h100;
    step();
    idle_inputs();
    step();
    checks += 2;
    if (rs_alu_dest_out !== 4'd5) begin errors++; $display("FAIL fwd_dest got %0d want 5", rs_alu_dest_out); end
    if (rs_alu_vj_out !== 32'h100) begin errors++; $display("FAIL fwd_vj got %h want 100", rs_alu_vj_out); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      dispatch(OP_ADD, 4'(k + 1), 32'd0, 4'd7, 32'(k), 4'd0, 32'd0, 32'(k));
      step();
    end
    idle_inputs();
    checks++;
    if (rs_dec_full_out !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", rs_dec_full_out); end
    alu_rs_h_in = 4'd7; alu_rs_result_in = 32'h77;
    step();
    idle_inputs();
    for (int k = 0; k < 8; k++) begin
      step();
      checks += 2;
      if (rs_alu_dest_out !== 4'(k + 1)) begin errors++; $display("FAIL fill_order got dest %0d want %0d", rs_alu_dest_out, k + 1); end
      if (rs_alu_vj_out !== 32'h77 || rs_alu_vk_out !== 32'(k)) begin errors++; $display("FAIL fill_vals got %h/%h want 77/%0d", rs_alu_vj_out, rs_alu_vk_out, k); end
    end
    step();
    checks += 2;
    if (rs_dec_full_out !== 1'b0) begin errors++; $display("FAIL fill_empty got full %b want 0", rs_dec_full_out); end
    if (rs_alu_opcode_out !== OP_NOP) begin errors++; $display("FAIL fill_done got op %0d want NOP", rs_alu_opcode_out); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      dispatch(OP_ADD, 4'(k + 1), 32'd0, 4'd5, 32'd0, 4'd0, 32'd0, 32'd0);
      step();
    end
    dispatch(OP_ADDI, 4'd12, 32'd1, 4'd0, 32'd0, 4'd0, 32'd3, 32'd0);
    alu_rs_h_in = 4'd5; alu_rs_result_in = 32'd1;
    rob_rs_rst_in = 1;
    step();
    idle_inputs();
    checks += 3;
    if (rs_alu_opcode_out !== OP_NOP || rs_alu_dest_out !== 4'd0) begin errors++; $display("FAIL flush_out got op %0d dest %0d want NOP/0", rs_alu_opcode_out, rs_alu_dest_out); end
    if (rs_alu_vj_out !== 32'd0) begin errors++; $display("FAIL flush_vj got %h want 0", rs_alu_vj_out); end
    if (rs_dec_full_out !== 1'b0) begin errors++; $display("FAIL flush_full got %b want 0", rs_dec_full_out); end
    alu_rs_h_in = 4'd5; alu_rs_result_in = 32'd1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (rs_alu_opcode_out !== OP_NOP) begin errors++; $display("FAIL flush_stale got op %0d dest %0d want NOP", rs_alu_opcode_out, rs_alu_dest_out); end
    end
    idle_inputs();
  endtask

  task automatic test_rdy_stall();
    dispatch(OP_ADD, 4'd9, 32'd11, 4'd0, 32'd22, 4'd0, 32'd0, 32'h40);
    step();
    dispatch(OP_ADD, 4'd10, 32'd33, 4'd0, 32'd44, 4'd0, 32'd0, 32'h44);
    step();
    checks++;
    if (rs_alu_dest_out !== 4'd9) begin errors++; $display("FAIL stall_pre got dest %0d want 9", rs_alu_dest_out); end
    dispatch(OP_ADDI, 4'd11, 32'd55, 4'd0, 32'd0, 4'd0, 32'd0, 32'h48);
    rdy_in = 0; alu_rs_h_in = 4'd3; alu_rs_result_in = 32'hdead;
    for (int k = 0; k < 3; k++) begin
      step();
      checks += 2;
      if (rs_alu_dest_out !== 4'd9 || rs_alu_opcode_out !== OP_ADD || rs_alu_vj_out !== 32'd11) begin
        errors++; $display("FAIL stall_hold got dest %0d op %0d vj %0d want 9/%0d/11", rs_alu_dest_out, rs_alu_opcode_out, rs_alu_vj_out, OP_ADD);
      end
      if (rs_dec_full_out !== 1'b0) begin errors++; $display("FAIL stall_full got %b want 0", rs_dec_full_out); end
    end
    idle_inputs();
    step();
    checks++;
    if (rs_alu_dest_out !== 4'd10 || rs_alu_vj_out !== 32'd33) begin errors++; $display("FAIL stall_resume got dest %0d vj %0d want 10/33", rs_alu_dest_out, rs_alu_vj_out); end
    step(); step();
    checks++;
    if (rs_alu_opcode_out !== OP_NOP) begin errors++; $display("FAIL stall_ignored got op %0d dest %0d want NOP", rs_alu_opcode_out, rs_alu_dest_out); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      idle_inputs();
      rdy_in = ($urandom_range(9) != 0);
      rob_rs_rst_in = ($urandom_range(59) == 0);
      if (!m_full() && $urandom_range(1) == 1) begin
        dispatch(6'($urandom_range(1, 5)), 4'($urandom_range(1, 15)), $urandom,
                 ($urandom_range(2) == 0) ? 4'd0 : 4'($urandom_range(1, 6)), $urandom,
                 ($urandom_range(2) == 0) ? 4'd0 : 4'($urandom_range(1, 6)), $urandom, $urandom);
      end
      if ($urandom_range(1) == 1) begin alu_rs_h_in = 4'($urandom_range(1, 6)); alu_rs_result_in = $urandom; end
      if ($urandom_range(2) == 0) begin lsb_rs_h_in = 4'($urandom_range(1, 6)); lsb_rs_result_in = $urandom; end
      if (lsb_rs_h_in == alu_rs_h_in) lsb_rs_h_in = 0;
      step();
      checks += 3;
      if (rs_alu_opcode_out !== e_op || rs_alu_dest_out !== e_dest) begin
        errors++; $display("FAIL rand_head cyc %0d got op %0d dest %0d want %0d/%0d", c, rs_alu_opcode_out, rs_alu_dest_out, e_op, e_dest);
      end
      if (rs_alu_vj_out !== e_vj || rs_alu_vk_out !== e_vk || rs_alu_a_out !== e_a || rs_alu_pc_out !== e_pc) begin
        errors++; $display("FAIL rand_data cyc %0d got %h %h %h %h want %h %h %h %h", c, rs_alu_vj_out, rs_alu_vk_out, rs_alu_a_out, rs_alu_pc_out, e_vj, e_vk, e_a, e_pc);
      end
      if (rs_dec_full_out !== m_full()) begin errors++; $display("FAIL rand_full cyc %0d got %b want %b", c, rs_dec_full_out, m_full()); end
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_busy[i] = 0; m_op[i] = 0; m_vj[i] = 0; m_vk[i] = 0; m_a[i] = 0;
      m_pc[i] = 0; m_qj[i] = 0; m_qk[i] = 0; m_dest[i] = 0;
    end
    e_op = OP_NOP; e_dest = 0; e_a = 0; e_vj = 0; e_vk = 0; e_pc = 0;
    idle_inputs();
    #1;
    test_reset();
    test_addi();
    test_wakeup();
    test_forward();
    test_fill();
    test_flush();
    test_rdy_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
